// File: rtl/ram_loader_if.sv
// Bus bundle between the UART RAM loader and its environment.
// The master side drives start/rx; the slave side (the loader) drives RAM and status outputs.
interface ram_loader_if #(
    parameter int A = 8
);
    logic         start;
    logic         rx;
    logic         ram_enable;
    logic [A-1:0] ram_addr;
    logic [7:0]   ram_data;
    logic         busy;
    logic         done;
    logic         frame_err;

    modport master (
        output start, rx,
        input  ram_enable, ram_addr, ram_data, busy, done, frame_err
    );

    modport slave (
        input  start, rx,
        output ram_enable, ram_addr, ram_data, busy, done, frame_err
    );
endinterface

// File: rtl/ram_loader.sv
// UART-fed RAM loader: receives a length byte, then that many data bytes,
// and writes them to consecutive RAM addresses starting at 0.
module ram_loader #(
    parameter int A            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    ram_loader_if.slave  bus
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {IDLE, LEN, DATA} ld_state_e;

    localparam int              CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    // Receiver state
    logic            sync1_q, sync2_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_evt, byte_good;

    // Loader state and registered outputs
    ld_state_e       ld_state_q, ld_state_d;
    logic [7:0]      rem_q, rem_d;
    logic [A-1:0]    addr_cnt_q, addr_cnt_d;
    logic            ram_enable_q, ram_enable_d;
    logic [A-1:0]    ram_addr_q, ram_addr_d;
    logic [7:0]      ram_data_q, ram_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            frame_err_q, frame_err_d;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_evt   = 1'b0;
        byte_good  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    byte_evt   = 1'b1;
                    byte_good  = sync2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        ld_state_d   = ld_state_q;
        rem_d        = rem_q;
        addr_cnt_d   = addr_cnt_q;
        ram_enable_d = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        frame_err_d  = frame_err_q;
        unique case (ld_state_q)
            IDLE: begin
                // Byte events here are dropped, even one coinciding with start.
                if (bus.start) begin
                    ld_state_d  = LEN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    frame_err_d = 1'b0;
                    addr_cnt_d  = '0;
                end
            end
            LEN: begin
                if (byte_evt && !byte_good) begin
                    ld_state_d  = IDLE;
                    busy_d      = 1'b0;
                    frame_err_d = 1'b1;
                end else if (byte_evt) begin
                    rem_d = shift_q;
                    if (shift_q == 8'd0) begin
                        ld_state_d = IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        ld_state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_evt && !byte_good) begin
                    ld_state_d  = IDLE;
                    busy_d      = 1'b0;
                    frame_err_d = 1'b1;
                end else if (byte_evt) begin
                    ram_enable_d = 1'b1;
                    ram_addr_d   = addr_cnt_q;
                    ram_data_d   = shift_q;
                    addr_cnt_d   = addr_cnt_q + 1'b1;
                    rem_d        = rem_q - 1'b1;
                    if (rem_q == 8'd1) begin
                        ld_state_d = IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: ld_state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            ld_state_q   <= IDLE;
            rem_q        <= '0;
            addr_cnt_q   <= '0;
            ram_enable_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= bus.rx;
            sync2_q      <= sync1_q;
            rx_prev_q    <= sync2_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            ld_state_q   <= ld_state_d;
            rem_q        <= rem_d;
            addr_cnt_q   <= addr_cnt_d;
            ram_enable_q <= ram_enable_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.ram_enable = ram_enable_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_data   = ram_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: serial frames in, logged RAM writes and flags checked.
module tb_ram_loader;
    localparam int A   = 8;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst;

    ram_loader_if #(.A(A)) bus ();

    ram_loader #(.A(A), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Write log gathered on the falling edge, away from the active edge.
    logic [A-1:0] log_addr[$];
    logic [7:0]   log_data[$];
    int           multi = 0;
    logic         en_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.ram_enable === 1'b1) begin
            log_addr.push_back(bus.ram_addr);
            log_data.push_back(bus.ram_data);
            if (en_prev) multi++;
        end
        en_prev = (bus.ram_enable === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // 8N1 frame followed by one idle bit time so the next start bit has a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(CPB);
        end
        bus.rx = stop_bit;
        tick(CPB);
        bus.rx = 1'b1;
        tick(CPB);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_en"},   32'(bus.ram_enable), 32'h0);
        check({tag, "_addr"}, 32'(bus.ram_addr),   32'h0);
        check({tag, "_data"}, 32'(bus.ram_data),   32'h0);
        check({tag, "_busy"}, 32'(bus.busy),       32'h0);
        check({tag, "_done"}, 32'(bus.done),       32'h0);
        check({tag, "_ferr"}, 32'(bus.frame_err),  32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bus.rx    = 1'b1;
        bus.start = 1'b0;
        rst       = 1'b1;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);
        check("post_reset_en", 32'(bus.ram_enable), 32'h0);

        // Bytes with no start: discarded, flags untouched.
        base = log_addr.size();
        send_byte(8'h5A, 1'b1);
        send_byte(8'h33, 1'b1);
        check("nostart_writes", 32'(log_addr.size() - base), 32'd0);
        check("nostart_busy",   32'(bus.busy),      32'h0);
        check("nostart_done",   32'(bus.done),      32'h0);
        check("nostart_ferr",   32'(bus.frame_err), 32'h0);

        // Basic load of three bytes.
        base = log_addr.size();
        pulse_start();
        check("s1_busy_after_start", 32'(bus.busy), 32'h1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        check("s1_writes", 32'(log_addr.size() - base), 32'd3);
        check("s1_addr0", 32'(log_addr[base+0]), 32'h00);
        check("s1_data0", 32'(log_data[base+0]), 32'hA1);
        check("s1_addr1", 32'(log_addr[base+1]), 32'h01);
        check("s1_data1", 32'(log_data[base+1]), 32'hB2);
        check("s1_addr2", 32'(log_addr[base+2]), 32'h02);
        check("s1_data2", 32'(log_data[base+2]), 32'hC3);
        check("s1_done", 32'(bus.done), 32'h1);
        check("s1_busy", 32'(bus.busy), 32'h0);
        check("s1_idle_en", 32'(bus.ram_enable), 32'h0);
        check("s1_hold_addr", 32'(bus.ram_addr), 32'h02);

        // Zero-length load.
        base = log_addr.size();
        pulse_start();
        check("s2_done_cleared", 32'(bus.done), 32'h0);
        send_byte(8'h00, 1'b1);
        check("s2_writes", 32'(log_addr.size() - base), 32'd0);
        check("s2_done",   32'(bus.done), 32'h1);
        check("s2_busy",   32'(bus.busy), 32'h0);

        // Framing error aborts the load after one write.
        base = log_addr.size();
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b0);
        check("s3_writes", 32'(log_addr.size() - base), 32'd1);
        check("s3_addr0",  32'(log_addr[base+0]), 32'h00);
        check("s3_data0",  32'(log_data[base+0]), 32'h55);
        check("s3_ferr",   32'(bus.frame_err), 32'h1);
        check("s3_busy",   32'(bus.busy), 32'h0);
        check("s3_done",   32'(bus.done), 32'h0);
        send_byte(8'h66, 1'b1);
        check("s3_no_more_writes", 32'(log_addr.size() - base), 32'd1);
        check("s3_ferr_sticky",    32'(bus.frame_err), 32'h1);

        // Short rx glitch in IDLE changes nothing.
        base = log_addr.size();
        bus.rx = 1'b0;
        tick(3);
        bus.rx = 1'b1;
        tick(40);
        check("s6_glitch_writes", 32'(log_addr.size() - base), 32'd0);
        check("s6_glitch_busy",   32'(bus.busy), 32'h0);
        check("s6_glitch_ferr",   32'(bus.frame_err), 32'h1);
        check("s6_glitch_done",   32'(bus.done), 32'h0);

        // Start pulse while busy is ignored.
        pulse_start();
        check("s6_ferr_cleared", 32'(bus.frame_err), 32'h0);
        send_byte(8'h02, 1'b1);
        send_byte(8'hD1, 1'b1);
        pulse_start();
        send_byte(8'hE2, 1'b1);
        check("s6_writes", 32'(log_addr.size() - base), 32'd2);
        check("s6_addr0",  32'(log_addr[base+0]), 32'h00);
        check("s6_data0",  32'(log_data[base+0]), 32'hD1);
        check("s6_addr1",  32'(log_addr[base+1]), 32'h01);
        check("s6_data1",  32'(log_data[base+1]), 32'hE2);
        check("s6_done",   32'(bus.done), 32'h1);
        check("s6_busy",   32'(bus.busy), 32'h0);

        // Reset in the middle of the second data byte, then a fresh load.
        base = log_addr.size();
        pulse_start();
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b1);
        check("s5_first_write", 32'(log_data[base+0]), 32'h11);
        bus.rx = 1'b0;
        tick(CPB);
        bus.rx = 1'b1;
        tick(CPB);
        bus.rx = 1'b0;
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        check_outputs_zero("s5_rst");
        bus.rx = 1'b1;
        rst    = 1'b0;
        tick(1);
        check("s5_no_write_after_rst", 32'(bus.ram_enable), 32'h0);
        tick(40);
        check("s5_rst_writes", 32'(log_addr.size() - base), 32'd1);
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b1);
        check("s5_writes", 32'(log_addr.size() - base), 32'd2);
        check("s5_addr",   32'(log_addr[base+1]), 32'h00);
        check("s5_data",   32'(log_data[base+1]), 32'h77);
        check("s5_done",   32'(bus.done), 32'h1);

        check("single_cycle_enable", 32'(multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
